// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for one shared, external
// combinational ALU. A granted request is latched, presented to the ALU for
// one cycle (EXEC) and its result is held as a response until it is consumed.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready[1:0] per-requester request handshake
//   req_a/req_b[63:0]        operands, requester i on [32i+31:32i]
//   req_op[5:0]              opcode, requester i on [3i+2:3i]
//   req_sa[9:0]              shift amount, requester i on [5i+4:5i]
//   alu_a/alu_b/alu_op/alu_sa  latched operands driven to the ALU
//   alu_r, alu_zero          ALU result and zero flag
//   rsp_valid/rsp_ready      response handshake
//   rsp_id, rsp_r, rsp_zero, rsp_skip  registered response payload
module alu_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  input  logic [5:0]  req_op,
  input  logic [9:0]  req_sa,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  output logic [4:0]  alu_sa,
  input  logic [31:0] alu_r,
  input  logic        alu_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_r,
  output logic        rsp_zero,
  output logic        rsp_skip
);

  localparam logic [2:0] OP_MOVZ = 3'b110;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state, state_next;
  logic        last_id;     // requester granted most recently
  logic        grant_id;
  logic        take;
  logic [31:0] lat_a, lat_b;
  logic [2:0]  lat_op;
  logic [4:0]  lat_sa;
  logic        lat_id;

  // On a tie the requester not granted last wins; reset leaves last_id = 1.
  always_comb begin
    grant_id   = (req_valid == 2'b11) ? ~last_id : req_valid[1];
    take       = (state == IDLE) && (|req_valid);
    req_ready  = '0;
    state_next = state;
    if (take && !rst) req_ready[grant_id] = 1'b1;
    case (state)
      IDLE:    if (take) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_id   <= 1'b1;
      lat_a     <= '0;
      lat_b     <= '0;
      lat_op    <= '0;
      lat_sa    <= '0;
      lat_id    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_r     <= '0;
      rsp_zero  <= 1'b0;
      rsp_skip  <= 1'b0;
    end else begin
      state <= state_next;
      if (take) begin
        lat_a   <= grant_id ? req_a[63:32] : req_a[31:0];
        lat_b   <= grant_id ? req_b[63:32] : req_b[31:0];
        lat_op  <= grant_id ? req_op[5:3]  : req_op[2:0];
        lat_sa  <= grant_id ? req_sa[9:5]  : req_sa[4:0];
        lat_id  <= grant_id;
        last_id <= grant_id;
      end
      if (state == EXEC) begin
        rsp_valid <= 1'b1;
        rsp_id    <= lat_id;
        // MOVZ with a non-zero condition operand suppresses the ALU result.
        if (lat_op == OP_MOVZ && lat_b != '0) begin
          rsp_r    <= '0;
          rsp_zero <= 1'b1;
          rsp_skip <= 1'b1;
        end else begin
          rsp_r    <= alu_r;
          rsp_zero <= alu_zero;
          rsp_skip <= 1'b0;
        end
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  assign alu_a  = lat_a;
  assign alu_b  = lat_b;
  assign alu_op = lat_op;
  assign alu_sa = lat_sa;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: supplies the shared ALU, runs directed scenarios and
// randomized traffic, and compares every cycle against a transaction model.
module tb_alu_arbiter;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                         XOR_ = 3'd4, SLT = 3'd5, MOVZ = 3'd6, SLL = 3'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  valid;
  logic [31:0] a0, a1, b0, b1;
  logic [2:0]  op0, op1;
  logic [4:0]  sa0, sa1;
  logic        rr;

  logic [1:0]  req_ready;
  logic [31:0] alu_a, alu_b, alu_r, rsp_r;
  logic [2:0]  alu_op;
  logic [4:0]  alu_sa;
  logic        alu_zero, rsp_valid, rsp_id, rsp_zero, rsp_skip;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(valid), .req_ready(req_ready),
    .req_a({a1, a0}), .req_b({b1, b0}), .req_op({op1, op0}), .req_sa({sa1, sa0}),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_sa(alu_sa),
    .alu_r(alu_r), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rr), .rsp_id(rsp_id),
    .rsp_r(rsp_r), .rsp_zero(rsp_zero), .rsp_skip(rsp_skip)
  );

  function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [4:0] sa);
    case (op)
      ADD:     return a + b;
      SUB:     return a - b;
      AND_:    return a & b;
      OR_:     return a | b;
      XOR_:    return a ^ b;
      SLT:     return (a < b) ? 32'd1 : 32'd0;
      MOVZ:    return a;
      default: return b << sa;
    endcase
  endfunction

  // The shared ALU the arbiter fronts.
  always_comb begin
    alu_r    = alu_fn(alu_op, alu_a, alu_b, alu_sa);
    alu_zero = (alu_r == 32'd0);
  end

  // Transaction model: an accepted request is 'age' cycles old; its response
  // is visible at age 2 and retires on the first cycle with rsp_ready high.
  logic        m_busy, m_last, m_id, m_clean;
  int unsigned m_age;
  logic [31:0] m_a, m_b;
  logic [2:0]  m_op;
  logic [4:0]  m_sa;
  logic        m_rv, m_rid, m_rz, m_rs;
  logic [31:0] m_rr;

  function automatic logic exp_grant();
    return (valid == 2'b11) ? ~m_last : valid[1];
  endfunction

  task automatic model_edge();
    logic g;
    if (rst) begin
      m_busy = 1'b0; m_age = 0; m_last = 1'b1; m_id = 1'b0; m_clean = 1'b1;
      m_a = '0; m_b = '0; m_op = '0; m_sa = '0;
      m_rv = 1'b0; m_rid = 1'b0; m_rr = '0; m_rz = 1'b0; m_rs = 1'b0;
    end else if (!m_busy) begin
      if (valid != 2'b00) begin
        g = exp_grant();
        m_last = g; m_id = g; m_busy = 1'b1; m_age = 1; m_clean = 1'b0;
        m_a  = g ? a1 : a0;
        m_b  = g ? b1 : b0;
        m_op = g ? op1 : op0;
        m_sa = g ? sa1 : sa0;
      end
    end else if (m_age == 1) begin
      m_age = 2; m_rv = 1'b1; m_rid = m_id;
      if (m_op == MOVZ && m_b != 0) begin
        m_rr = 0; m_rz = 1'b1; m_rs = 1'b1;
      end else begin
        m_rr = alu_fn(m_op, m_a, m_b, m_sa); m_rz = (m_rr == 0); m_rs = 1'b0;
      end
    end else if (rr) begin
      m_busy = 1'b0; m_rv = 1'b0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs are already driven; compare mid-cycle, then advance one edge.
  task automatic tick();
    logic [1:0] exp_ready;
    #4;
    exp_ready = (!rst && !m_busy && valid != 2'b00) ? (2'b01 << exp_grant()) : 2'b00;
    check("req_ready", {30'd0, req_ready}, {30'd0, exp_ready});
    check("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_rv});
    check("alu_a", alu_a, m_a);
    check("alu_b", alu_b, m_b);
    check("alu_op", {29'd0, alu_op}, {29'd0, m_op});
    check("alu_sa", {27'd0, alu_sa}, {27'd0, m_sa});
    if (m_rv || m_clean) begin
      check("rsp_id", {31'd0, rsp_id}, {31'd0, m_rid});
      check("rsp_r", rsp_r, m_rr);
      check("rsp_zero", {31'd0, rsp_zero}, {31'd0, m_rz});
      check("rsp_skip", {31'd0, rsp_skip}, {31'd0, m_rs});
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_req(input logic id, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sa);
    if (id) begin op1 = op; a1 = a; b1 = b; sa1 = sa; end
    else    begin op0 = op; a0 = a; b0 = b; sa0 = sa; end
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = 2'b00;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    valid = 2'b00;
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1; valid = 2'b00; rr = 1'b1;
    a0 = '0; a1 = '0; b0 = '0; b1 = '0; op0 = '0; op1 = '0; sa0 = '0; sa1 = '0;
    @(posedge clk);
    model_edge();
    #1;
    do_reset();

    // Single ADD from requester 0.
    set_req(1'b0, ADD, 32'd5, 32'd7, 5'd0);
    valid = 2'b01; tick();
    idle(4);

    // Both requesters contend for 9 cycles after a reset.
    do_reset();
    set_req(1'b0, SUB, 32'd9, 32'd9, 5'd0);
    set_req(1'b1, OR_, 32'h0000_00F0, 32'h0000_000F, 5'd0);
    valid = 2'b11;
    for (int unsigned i = 0; i < 9; i++) tick();
    idle(4);

    // MOVZ skipped, then taken.
    set_req(1'b1, MOVZ, 32'h0000_1234, 32'd3, 5'd0);
    valid = 2'b10; tick();
    idle(4);
    set_req(1'b1, MOVZ, 32'h0000_1234, 32'd0, 5'd0);
    valid = 2'b10; tick();
    idle(4);

    // SLL with the consumer stalled for four cycles in RESP.
    set_req(1'b0, SLL, 32'hDEAD_BEEF, 32'd1, 5'd31);
    valid = 2'b01; tick();
    valid = 2'b00; rr = 1'b0;
    for (int unsigned i = 0; i < 5; i++) tick();
    rr = 1'b1;
    idle(3);

    // Reset during EXEC aborts the transaction; next tie goes to requester 0.
    set_req(1'b1, ADD, 32'd1, 32'd2, 5'd0);
    valid = 2'b10; tick();
    valid = 2'b00; rst = 1'b1; tick();
    rst = 1'b0; tick();
    valid = 2'b11; tick();
    idle(4);

    // SLT is an unsigned compare.
    set_req(1'b0, SLT, 32'd3, 32'hFFFF_FFFF, 5'd0);
    valid = 2'b01; tick();
    idle(4);

    // Randomized traffic with stalls and occasional resets.
    for (int unsigned i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 39) == 0);
      valid = 2'($urandom_range(0, 3));
      rr    = ($urandom_range(0, 3) != 0);
      for (int unsigned k = 0; k < 2; k++) begin
        set_req(k[0], 3'($urandom_range(0, 7)),
                ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
                ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
                5'($urandom_range(0, 31)));
      end
      tick();
    end
    rst = 1'b0; rr = 1'b1;
    idle(4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: req_valid  input  2  per-requester request valid; bit i = requester i.
REQ-004 SHALL have port: req_ready  output  2  per-requester accept strobe; at most one bit high.
REQ-005 SHALL have port: req_a  input  64  operand a; requester i on bits [32i+31:32i].
REQ-006 SHALL have port: req_b  input  64  operand b; same packing as req_a.
REQ-007 SHALL have port: req_op  input  6  ALU opcode; requester i on bits [3i+2:3i]; codes ADD 000, SUB 001, AND 010, OR 011, XOR 100, SLT 101, MOVZ 110, SLL 111.
REQ-008 SHALL have port: req_sa  input  10  shift amount; requester i on bits [5i+4:5i].
REQ-009 SHALL have port: alu_a / alu_b  output  32 each  operands to the shared ALU.
REQ-010 SHALL have port: alu_op  output  3  opcode to the ALU.
REQ-011 SHALL have port: alu_sa  output  5  shift amount to the ALU.
REQ-012 SHALL have port: alu_r  input  32  ALU result; combinational from alu_* outputs.
REQ-013 SHALL have port: alu_zero  input  1  ALU zero flag.
REQ-014 SHALL have port: rsp_valid  output  1  response valid.
REQ-015 SHALL have port: rsp_ready  input  1  response consumer ready.
REQ-016 SHALL have port: rsp_id  output  1  index of the requester that owns the response.
REQ-017 SHALL have port: rsp_r  output  32  registered result.
REQ-018 SHALL have port: rsp_zero  output  1  registered zero flag.
REQ-019 SHALL have port: rsp_skip  output  1  MOVZ condition false; result not written.

Function
REQ-020 SHALL implement FSM states IDLE, EXEC, RESP; IDLE->EXEC on grant, EXEC->RESP unconditionally after one cycle, RESP->IDLE on rsp_valid & rsp_ready.
REQ-021 SHALL, in IDLE with any req_valid high, grant exactly one requester: the only valid one, or if both are valid, the one not granted most recently (round-robin pointer).
REQ-022 SHALL drive req_ready[g] high combinationally only in IDLE for the granted g; handshake = req_valid[g] & req_ready[g].
REQ-023 SHALL latch a, b, op, sa and id of the granted requester into internal registers on the handshake edge; the pointer SHALL update only on a grant.
REQ-024 SHALL drive alu_a/alu_b/alu_op/alu_sa from the latched registers in every state; inputs SHALL NOT change while EXEC or RESP.
REQ-025 SHALL, at the end of the EXEC cycle, capture alu_r into rsp_r and alu_zero into rsp_zero, and set rsp_valid.
REQ-026 SHALL, for op MOVZ with latched b != 0, capture rsp_r = 0, rsp_zero = 1, rsp_skip = 1 and ignore alu_r; otherwise rsp_skip = 0.
REQ-027 SHALL hold rsp_valid, rsp_id, rsp_r, rsp_zero and rsp_skip stable in RESP until rsp_ready; req_ready SHALL be 0 throughout EXEC and RESP.
REQ-028 SHALL give a latency of 2 cycles from the accept edge to rsp_valid high; minimum issue interval 3 cycles (accept, EXEC, RESP with rsp_ready=1).
REQ-029 SHALL ignore req_valid deasserted before grant; no request is remembered across cycles outside the latched registers.
REQ-030 SHALL tolerate rsp_ready held high permanently: RESP then lasts exactly one cycle.

Reset
REQ-031 SHALL, when rst is high at a clock edge, enter IDLE, set rsp_valid, rsp_id, rsp_r, rsp_zero, rsp_skip and all latched operand/op/sa registers to 0, set the pointer so that requester 0 wins the next tie, and drive req_ready = 00 during reset.
REQ-032 SHALL abort any in-flight transaction on mid-operation reset with no response emitted; the first grant after reset SHALL occur no earlier than the first edge with rst low.

Verification
REQ-033 SHALL pass: after reset, req0 ADD a=5 b=7 alone, rsp_ready=1 -> req_ready=01 in cycle 0, rsp_valid in cycle 2 with rsp_id=0, rsp_r=12, rsp_zero=0.
REQ-034 SHALL pass: both requesters held valid (req0 SUB 9-9, req1 OR 0xF0|0x0F) for 9 cycles -> grants in order 0,1,0, responses r=0/zero=1, r=0xFF, r=0.
REQ-035 SHALL pass: req1 MOVZ a=0x1234 b=3 -> rsp_skip=1, rsp_r=0, rsp_zero=1; then MOVZ b=0 -> rsp_skip=0, rsp_r=0x1234.
REQ-036 SHALL pass: SLL b=1 sa=31 with rsp_ready low for 4 cycles -> rsp_valid and rsp_r=0x80000000 stable, req_ready=00, alu_* stable for all 4 cycles.
REQ-037 SHALL pass: rst asserted in the EXEC cycle -> no rsp_valid pulse; all outputs 0 the following cycle; next tie granted to requester 0.
REQ-038 SHALL pass: SLT a=3 b=0xFFFFFFFF -> rsp_r=1 (unsigned compare).
